// File: rtl/cu_pkg.sv
// cu_pkg: opcode constants, FSM states and instruction classes shared by the control unit.
package cu_pkg;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
    OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110,
    OP_ROR = 5'b00111, OP_ROL = 5'b01000, OP_SHR = 5'b01001, OP_SHRA = 5'b01010,
    OP_SHL = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110,
    OP_DIV = 5'b01111, OP_MUL = 5'b10000, OP_NEG = 5'b10001, OP_NOT = 5'b10010,
    OP_BR = 5'b10011, OP_JR = 5'b10100, OP_JAL = 5'b10101, OP_IN = 5'b10110,
    OP_OUT = 5'b10111, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP = 5'b11010,
    OP_HALT = 5'b11011;

  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} cuState;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST,
    CL_BR, CL_JR, CL_MOVE, CL_IO, CL_NOP, CL_HALT
  } instrClass;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: maps a 5-bit opcode to its execute-sequence class.
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0] opcode,
  output instrClass  cls
);
  always_comb begin
    cls = CL_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: cls = CL_IMM;
      OP_MUL, OP_DIV: cls = CL_MULDIV;
      OP_NEG, OP_NOT: cls = CL_UNARY;
      OP_LD: cls = CL_LD;
      OP_LDI: cls = CL_LDI;
      OP_ST: cls = CL_ST;
      OP_BR: cls = CL_BR;
      OP_JR: cls = CL_JR;
      OP_MFHI, OP_MFLO: cls = CL_MOVE;
      OP_IN, OP_OUT: cls = CL_IO;
      OP_HALT: cls = CL_HALT;
      OP_NOP, OP_JAL: cls = CL_NOP;
      default: cls = CL_NOP;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer with memory wait states and halt/stop.
// Define CU_INSTR_COUNT_EN to add the retired-instruction counter output instr_count.
module control_unit
  import cu_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        branchFlag,
  input  logic        stop,
  output logic        run,
  output logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread, RAMwrite,
  output logic        RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin, HIout, LOout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, RCout,
  output logic        CONin, InPortOut, OutPortIn
`ifdef CU_INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);
  cuState state, nextState;
  instrClass cls;
  logic [2:0] waitCnt;
  logic [4:0] opcode;
  logic unusedIr;
  logic t0, t1, t2, t3, t4, t5, t6, t7;
  logic isAlu, isImm, isMulDiv, isUnary, isLd, isLdi, isSt, isBr, isJr, isMove, isIo, isNop;
  logic addrCalc, yzGroup, isMem, hold, done;

  assign opcode = IR[31:27];
  assign unusedIr = ^IR[26:0];

  cu_decode uDecode (.opcode(opcode), .cls(cls));

  assign {t0, t1, t2, t3} = {state == T0, state == T1, state == T2, state == T3};
  assign {t4, t5, t6, t7} = {state == T4, state == T5, state == T6, state == T7};
  assign {isAlu, isImm, isMulDiv, isUnary} = {cls == CL_ALU, cls == CL_IMM, cls == CL_MULDIV, cls == CL_UNARY};
  assign {isLd, isLdi, isSt, isBr} = {cls == CL_LD, cls == CL_LDI, cls == CL_ST, cls == CL_BR};
  assign {isJr, isMove, isIo, isNop} = {cls == CL_JR, cls == CL_MOVE, cls == CL_IO, cls == CL_NOP};
  assign addrCalc = isLd | isLdi | isSt;
  assign yzGroup = isAlu | isImm | isMulDiv | addrCalc;

  // Memory steps stretch while the wait counter is non-zero; it reloads in every other cycle.
  assign isMem = t1 | (t6 & isLd) | (t7 & isSt);
  assign hold = isMem && waitCnt != 3'd0;
  assign done = (t3 & (isJr | isMove | isIo | isNop)) | (t4 & isUnary) | (t5 & (isAlu | isImm | isLdi))
              | (t6 & (isMulDiv | isBr)) | (t7 & (isLd | isSt) & ~hold);

  always_comb begin
    nextState = state;
    case (state)
      RESET: nextState = T0;
      T0: nextState = T1;
      T1: nextState = hold ? T1 : T2;
      T2: nextState = T3;
      T3: nextState = (cls == CL_HALT) ? HALT : T4;
      T4: nextState = T5;
      T5: nextState = T6;
      T6: nextState = hold ? T6 : T7;
      T7: nextState = hold ? T7 : T0;
      HALT: nextState = HALT;
      default: nextState = RESET;
    endcase
    if (done) nextState = stop ? HALT : T0;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= RESET;
      waitCnt <= 3'(MEM_WAIT);
    end else begin
      state <= nextState;
      waitCnt <= hold ? waitCnt - 3'd1 : 3'(MEM_WAIT);
    end
  end

`ifdef CU_INSTR_COUNT_EN
  always_ff @(posedge clock) begin
    if (!clear) instr_count <= '0;
    else if (done) instr_count <= instr_count + 32'd1;
  end
`endif

  assign run = state != RESET && state != HALT;
  assign PCout = t0 | (t4 & isBr);
  assign PCin = t0 | (t3 & isJr) | (t6 & isBr & branchFlag);
  assign IncPC = t0;
  assign IRin = t2;
  assign MARin = t0 | (t5 & (isLd | isSt));
  assign MDRin = t1 | (t6 & (isLd | isSt));
  assign MDRout = t2 | (t7 & isLd);
  assign MDRread = t1 | (t6 & isLd);
  assign RAMwrite = t7 & isSt;
  assign RYin = (t3 & yzGroup) | (t4 & isBr);
  assign RZinLo = (t4 & yzGroup) | (t3 & isUnary) | (t5 & isBr);
  assign RZinHi = t4 & isMulDiv;
  assign RZoutLo = (t5 & yzGroup) | (t4 & isUnary) | (t6 & isBr & branchFlag);
  assign RZoutHi = t6 & isMulDiv;
  assign HIin = t6 & isMulDiv;
  assign LOin = t5 & isMulDiv;
  assign HIout = t3 & isMove & (opcode == OP_MFHI);
  assign LOout = t3 & isMove & (opcode == OP_MFLO);
  assign Gra = (t3 & (isMulDiv | isBr | isJr | isMove | isIo)) | (t4 & isUnary)
             | (t5 & (isAlu | isImm | isLdi)) | (t6 & isSt) | (t7 & isLd);
  assign Grb = (t3 & (isAlu | isImm | isUnary | addrCalc)) | (t4 & isMulDiv);
  assign Grc = t4 & isAlu;
  assign Rin = (t3 & (isMove | (isIo & opcode == OP_IN))) | (t4 & isUnary)
             | (t5 & (isAlu | isImm | isLdi)) | (t7 & isLd);
  assign Rout = (t3 & (isAlu | isImm | isMulDiv | isUnary | isBr | isJr | (isIo & opcode == OP_OUT)))
              | (t4 & (isAlu | isMulDiv)) | (t6 & isSt);
  assign BAout = t3 & addrCalc;
  assign RCout = (t4 & (isImm | addrCalc)) | (t5 & isBr);
  assign CONin = t3 & isBr;
  assign InPortOut = t3 & isIo & (opcode == OP_IN);
  assign OutPortIn = t3 & isIo & (opcode == OP_OUT);
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized self-checking bench comparing per-cycle strobes against a step-table model.
module tb_control_unit;
  localparam int MEM_WAIT = 2;
  localparam int FETCH_LEN = 3 + MEM_WAIT;
  localparam logic [28:0] PCOUT = 29'd1 << 0, PCIN = 29'd1 << 1, INCPC = 29'd1 << 2, IRIN = 29'd1 << 3,
    MARIN = 29'd1 << 4, MDRIN = 29'd1 << 5, MDROUT = 29'd1 << 6, MDRREAD = 29'd1 << 7,
    RAMWRITE = 29'd1 << 8, RYIN = 29'd1 << 9, RZINLO = 29'd1 << 10, RZINHI = 29'd1 << 11,
    RZOUTLO = 29'd1 << 12, RZOUTHI = 29'd1 << 13, HIIN = 29'd1 << 14, LOIN = 29'd1 << 15,
    HIOUT = 29'd1 << 16, LOOUT = 29'd1 << 17, GRA = 29'd1 << 18, GRB = 29'd1 << 19,
    GRC = 29'd1 << 20, RIN = 29'd1 << 21, ROUT = 29'd1 << 22, BAOUT = 29'd1 << 23,
    RCOUT = 29'd1 << 24, CONIN = 29'd1 << 25, INPORTOUT = 29'd1 << 26, OUTPORTIN = 29'd1 << 27,
    RUN = 29'd1 << 28;
  localparam logic [28:0] FETCH0 = RUN | PCOUT | MARIN | INCPC | PCIN;
  localparam logic [28:0] BUS = PCOUT | MDROUT | RZOUTLO | RZOUTHI | HIOUT | LOOUT | INPORTOUT | RCOUT | ROUT;

  logic clock = 0, clear = 0, branchFlag = 0, stop = 0;
  logic [31:0] IR = '0;
  logic run, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread, RAMwrite;
  logic RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin, HIout, LOout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin, InPortOut, OutPortIn;
`ifdef CU_INSTR_COUNT_EN
  logic [31:0] instrCount;
`endif
  logic [28:0] obs;
  logic [28:0] expQ[$], gotQ[$];
  int errors = 0, checks = 0;

  control_unit #(.MEM_WAIT(MEM_WAIT)) dut (
    .clock(clock), .clear(clear), .IR(IR), .branchFlag(branchFlag), .stop(stop), .run(run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MDRread(MDRread), .RAMwrite(RAMwrite), .RYin(RYin), .RZinLo(RZinLo),
    .RZinHi(RZinHi), .RZoutLo(RZoutLo), .RZoutHi(RZoutHi), .HIin(HIin), .LOin(LOin),
    .HIout(HIout), .LOout(LOout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .RCout(RCout), .CONin(CONin), .InPortOut(InPortOut), .OutPortIn(OutPortIn)
`ifdef CU_INSTR_COUNT_EN
    , .instr_count(instrCount)
`endif
  );

  assign obs = {run, OutPortIn, InPortOut, CONin, RCout, BAout, Rout, Rin, Grc, Grb, Gra, LOout, HIout,
                LOin, HIin, RZoutHi, RZoutLo, RZinHi, RZinLo, RYin, RAMwrite, MDRread, MDRout, MDRin,
                MARin, IRin, IncPC, PCin, PCout};

  always #5 clock = ~clock;

  task automatic push(input logic [28:0] v);
    expQ.push_back(RUN | v);
  endtask

  task automatic pushMem(input logic [28:0] v);
    repeat (MEM_WAIT + 1) push(v);
  endtask

  // One queue entry per clock from T0 to the final step, straight from the step tables.
  task automatic buildExp(input logic [4:0] op, input logic flag);
    expQ.delete();
    push(PCOUT | MARIN | INCPC | PCIN);
    pushMem(MDRREAD | MDRIN);
    push(MDROUT | IRIN);
    if (op inside {[5'd3:5'd11]}) begin
      push(GRB | ROUT | RYIN); push(GRC | ROUT | RZINLO); push(RZOUTLO | GRA | RIN);
    end else if (op inside {[5'd12:5'd14]}) begin
      push(GRB | ROUT | RYIN); push(RCOUT | RZINLO); push(RZOUTLO | GRA | RIN);
    end else if (op inside {5'd15, 5'd16}) begin
      push(GRA | ROUT | RYIN); push(GRB | ROUT | RZINLO | RZINHI); push(RZOUTLO | LOIN); push(RZOUTHI | HIIN);
    end else if (op inside {5'd17, 5'd18}) begin
      push(GRB | ROUT | RZINLO); push(RZOUTLO | GRA | RIN);
    end else if (op <= 5'd2) begin
      push(GRB | BAOUT | RYIN); push(RCOUT | RZINLO);
      if (op == 5'd1) push(RZOUTLO | GRA | RIN);
      else begin
        push(RZOUTLO | MARIN);
        if (op == 5'd0) begin pushMem(MDRREAD | MDRIN); push(MDROUT | GRA | RIN); end
        else begin push(GRA | ROUT | MDRIN); pushMem(RAMWRITE); end
      end
    end else if (op == 5'd19) begin
      push(GRA | ROUT | CONIN); push(PCOUT | RYIN); push(RCOUT | RZINLO); push(flag ? (RZOUTLO | PCIN) : '0);
    end else if (op == 5'd20) push(GRA | ROUT | PCIN);
    else if (op == 5'd22) push(INPORTOUT | GRA | RIN);
    else if (op == 5'd23) push(GRA | ROUT | OUTPORTIN);
    else if (op == 5'd24) push(HIOUT | GRA | RIN);
    else if (op == 5'd25) push(LOOUT | GRA | RIN);
    else push('0);
  endtask

  // Starts in T0; IR changes as the datapath would load it, at the end of T2.
  task automatic runInstr(input logic [31:0] ir, input logic flag, input int abortAt, input int stopAt);
    buildExp(ir[31:27], flag);
    gotQ.delete();
    branchFlag = flag;
    for (int k = 0; k < expQ.size(); k++) begin
      gotQ.push_back(obs);
      if (k == FETCH_LEN - 1) IR = ir;
      if (k == stopAt) stop = 1;
      if (k == abortAt) clear = 0;
      @(posedge clock); #1;
      if (k == abortAt) break;
    end
  endtask

  task automatic pulseClear;
    clear = 0; @(posedge clock); #1;
    clear = 1; @(posedge clock); #1;
  endtask

  task automatic test_reset;
    clear = 0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=%h", obs, 29'd0); end
    clear = 1; @(posedge clock); #1;
    checks++;
    if (obs !== FETCH0) begin errors++; $display("FAIL reset_to_T0 got=%h want=%h", obs, FETCH0); end
  endtask

  task automatic test_add;
    runInstr(32'h1A2B8000, 1'b0, -1, -1);
    foreach (gotQ[k]) begin
      checks++;
      if (gotQ[k] !== expQ[k]) begin errors++; $display("FAIL add step%0d got=%h want=%h", k, gotQ[k], expQ[k]); end
    end
    checks++;
    if (obs !== FETCH0) begin errors++; $display("FAIL add_back_to_T0 got=%h want=%h", obs, FETCH0); end
  endtask

  task automatic test_ld;
    int n = 0;
    runInstr({5'b00000, 27'($urandom)}, 1'b0, -1, -1);
    foreach (gotQ[k]) begin
      checks++;
      if (gotQ[k] !== expQ[k]) begin errors++; $display("FAIL ld step%0d got=%h want=%h", k, gotQ[k], expQ[k]); end
      if (gotQ[k][7]) n++;
    end
    checks++;
    if (n != 2 * (MEM_WAIT + 1)) begin errors++; $display("FAIL ld_read_cycles got=%0d want=%0d", n, 2 * (MEM_WAIT + 1)); end
    checks++;
    if (obs !== FETCH0) begin errors++; $display("FAIL ld_back_to_T0 got=%h want=%h", obs, FETCH0); end
  endtask

  task automatic test_br;
    for (int f = 1; f >= 0; f--) begin
      runInstr({5'b10011, 27'($urandom)}, f[0], -1, -1);
      foreach (gotQ[k]) begin
        checks++;
        if (gotQ[k] !== expQ[k]) begin errors++; $display("FAIL br%0d step%0d got=%h want=%h", f, k, gotQ[k], expQ[k]); end
      end
      checks++;
      if (obs !== FETCH0) begin errors++; $display("FAIL br%0d_back_to_T0 got=%h want=%h", f, obs, FETCH0); end
    end
  endtask

  task automatic test_halt;
    runInstr({5'b11011, 27'($urandom)}, 1'b0, -1, -1);
    foreach (gotQ[k]) begin
      checks++;
      if (gotQ[k] !== expQ[k]) begin errors++; $display("FAIL halt step%0d got=%h want=%h", k, gotQ[k], expQ[k]); end
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL halted_cycle%0d got=%h want=%h", c, obs, 29'd0); end
      @(posedge clock); #1;
    end
    pulseClear();
    checks++;
    if (obs !== FETCH0) begin errors++; $display("FAIL halt_recover got=%h want=%h", obs, FETCH0); end
  endtask

  task automatic test_stop;
    runInstr({5'b10000, 27'($urandom)}, 1'b0, -1, FETCH_LEN + 1);
    foreach (gotQ[k]) begin
      checks++;
      if (gotQ[k] !== expQ[k]) begin errors++; $display("FAIL stop_mul step%0d got=%h want=%h", k, gotQ[k], expQ[k]); end
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL stop_halted%0d got=%h want=%h", c, obs, 29'd0); end
      @(posedge clock); #1;
    end
    stop = 0;
    pulseClear();
    checks++;
    if (obs !== FETCH0) begin errors++; $display("FAIL stop_recover got=%h want=%h", obs, FETCH0); end
  endtask

  task automatic test_mid_reset;
    runInstr({5'b00010, 27'($urandom)}, 1'b0, FETCH_LEN + 2, -1);
    foreach (gotQ[k]) begin
      checks++;
      if (gotQ[k] !== expQ[k]) begin errors++; $display("FAIL st_abort step%0d got=%h want=%h", k, gotQ[k], expQ[k]); end
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL st_abort_reset%0d got=%h want=%h", c, obs, 29'd0); end
      @(posedge clock); #1;
    end
    clear = 1; @(posedge clock); #1;
    checks++;
    if (obs !== FETCH0) begin errors++; $display("FAIL st_abort_restart got=%h want=%h", obs, FETCH0); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      runInstr({op, 27'($urandom)}, 1'($urandom), -1, -1);
      foreach (gotQ[k]) begin
        checks++;
        if (gotQ[k] !== expQ[k]) begin errors++; $display("FAIL rand op=%b step%0d got=%h want=%h", op, k, gotQ[k], expQ[k]); end
        checks++;
        if ($countones(gotQ[k] & BUS) > 1) begin errors++; $display("FAIL bus_exclusive op=%b step%0d got=%h want=at most one driver", op, k, gotQ[k]); end
      end
    end
    checks++;
    if (obs !== FETCH0) begin errors++; $display("FAIL rand_back_to_T0 got=%h want=%h", obs, FETCH0); end
  endtask

`ifdef CU_INSTR_COUNT_EN
  task automatic test_count;
    pulseClear();
    checks++;
    if (instrCount !== 32'd0) begin errors++; $display("FAIL count_clear got=%0d want=0", instrCount); end
    repeat (5) runInstr({5'b11010, 27'd0}, 1'b0, -1, -1);
    checks++;
    if (instrCount !== 32'd5) begin errors++; $display("FAIL count_nops got=%0d want=5", instrCount); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_br();
    test_halt();
    test_stop();
    test_mid_reset();
    test_random();
`ifdef CU_INSTR_COUNT_EN
    test_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
